// File: rtl/buffered_uart_tx_param.sv
// Buffered UART transmitter: synchronous FIFO feeding a parametrised serializer.
// Defining BUF_UART_TX_CTS_EN adds an active-low cts_n input that gates new frames.
module buffered_uart_tx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        data,
  input  logic                        data_valid,
  output logic                        data_ready,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        busy,
  output logic                        uart_tx
`ifdef BUF_UART_TX_CTS_EN
  ,
  input  logic                        cts_n
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  function automatic logic frame_parity(input logic [DATA_BITS-1:0] word);
    logic p;
    p = ^word;
    if (PARITY == 1) begin
      frame_parity = ~p;
    end else begin
      frame_parity = p;
    end
  endfunction

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_r;
  logic [PW-1:0]        rd_ptr_r;
  logic [LW-1:0]        level_r;
  logic                 overflow_r;

  state_t               state_r;
  state_t               next_state_s;
  logic [CW-1:0]        cnt_r;
  logic [CW-1:0]        next_cnt_s;
  logic [IW-1:0]        idx_r;
  logic [IW-1:0]        next_idx_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] next_shift_s;
  logic                 par_r;
  logic                 next_par_s;
  logic                 tx_r;
  logic                 next_tx_s;

  logic                 push_s;
  logic                 pop_s;
  logic                 can_pop_s;
  logic                 bit_end_s;
  logic [DATA_BITS-1:0] head_s;

  assign full       = (level_r == LW'(FIFO_DEPTH));
  assign empty      = (level_r == {LW{1'b0}});
  assign data_ready = ~full;
  assign level      = level_r;
  assign overflow   = overflow_r;
  assign busy       = (state_r != ST_IDLE);
  assign uart_tx    = tx_r;

  assign push_s    = data_valid & ~full;
  assign head_s    = mem_r[rd_ptr_r];
  assign bit_end_s = (cnt_r == CNT_LAST);
`ifdef BUF_UART_TX_CTS_EN
  assign can_pop_s = ~empty & ~cts_n;
`else
  assign can_pop_s = ~empty;
`endif

  // FIFO storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      level_r    <= {LW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      level_r <= level_r + LW'(push_s) - LW'(pop_s);
      if (data_valid & full) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Serializer state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      idx_r   <= {IW{1'b0}};
      shift_r <= {DATA_BITS{1'b0}};
      par_r   <= 1'b0;
      tx_r    <= 1'b1;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= next_cnt_s;
      idx_r   <= next_idx_s;
      shift_r <= next_shift_s;
      par_r   <= next_par_s;
      tx_r    <= next_tx_s;
    end
  end

  // Next-state logic; the line value is computed for the coming bit and registered.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    next_idx_s   = idx_r;
    next_shift_s = shift_r;
    next_par_s   = par_r;
    next_tx_s    = tx_r;
    pop_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (can_pop_s) begin
          pop_s        = 1'b1;
          next_state_s = ST_START;
          next_cnt_s   = {CW{1'b0}};
          next_shift_s = head_s;
          next_par_s   = frame_parity(head_s);
          next_tx_s    = 1'b0;
        end else begin
          next_state_s = ST_IDLE;
          next_tx_s    = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          next_state_s = ST_DATA;
          next_cnt_s   = {CW{1'b0}};
          next_idx_s   = {IW{1'b0}};
          next_tx_s    = shift_r[0];
        end else begin
          next_cnt_s   = cnt_r + CW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          next_cnt_s = {CW{1'b0}};
          if (idx_r == DATA_LAST) begin
            if (PARITY != 0) begin
              next_state_s = ST_PAR;
              next_tx_s    = par_r;
            end else begin
              next_state_s = ST_STOP;
              next_idx_s   = {IW{1'b0}};
              next_tx_s    = 1'b1;
            end
          end else begin
            next_idx_s   = idx_r + IW'(1);
            next_shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
            next_tx_s    = shift_r[1];
          end
        end else begin
          next_cnt_s = cnt_r + CW'(1);
        end
      end
      ST_PAR: begin
        if (bit_end_s) begin
          next_state_s = ST_STOP;
          next_cnt_s   = {CW{1'b0}};
          next_idx_s   = {IW{1'b0}};
          next_tx_s    = 1'b1;
        end else begin
          next_cnt_s   = cnt_r + CW'(1);
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          next_cnt_s = {CW{1'b0}};
          if (idx_r == STOP_LAST) begin
            // Chain straight into the next start bit when more data is waiting.
            if (can_pop_s) begin
              pop_s        = 1'b1;
              next_state_s = ST_START;
              next_shift_s = head_s;
              next_par_s   = frame_parity(head_s);
              next_tx_s    = 1'b0;
            end else begin
              next_state_s = ST_IDLE;
              next_tx_s    = 1'b1;
            end
          end else begin
            next_idx_s = idx_r + IW'(1);
          end
        end else begin
          next_cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        next_cnt_s   = {CW{1'b0}};
        next_tx_s    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_buffered_uart_tx_param.sv
// Bench for buffered_uart_tx_param: three framing configurations driven together and
// compared every cycle against a frame-level queue model.
module tb_buffered_uart_tx_param;

  localparam int C  = 4;
  localparam int NI = 3;
  // instance 0: 8E1 depth 16, instance 1: 8O1 depth 4, instance 2: 7N2 depth 16
  localparam int D0 = 8, DEP0 = 16, PAR0 = 2, SB0 = 1;
  localparam int D1 = 8, DEP1 = 4,  PAR1 = 1, SB1 = 1;
  localparam int D2 = 7, DEP2 = 16, PAR2 = 0, SB2 = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d0 = 8'h00;
  logic [7:0] d1 = 8'h00;
  logic [6:0] d2 = 7'h00;
  logic       dv  [NI];
  logic       tx  [NI];
  logic       bsy [NI];
  logic       ful [NI];
  logic       emp [NI];
  logic       ovf [NI];
  logic       rdy [NI];
  logic [4:0] lvl0;
  logic [2:0] lvl1;
  logic [4:0] lvl2;
`ifdef BUF_UART_TX_CTS_EN
  logic       cts [NI];
`endif

  logic [8:0] mq [NI][$];
  int         fs   [NI];
  bit         act  [NI];
  logic [8:0] fd   [NI];
  bit         movf [NI];
  int         cyc   = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  buffered_uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(D0), .FIFO_DEPTH(DEP0),
                           .PARITY(PAR0), .STOP_BITS(SB0)) dut_a (
    .clk(clk), .rst(rst), .data(d0), .data_valid(dv[0]), .data_ready(rdy[0]),
    .full(ful[0]), .empty(emp[0]), .level(lvl0), .overflow(ovf[0]), .busy(bsy[0]),
    .uart_tx(tx[0])
`ifdef BUF_UART_TX_CTS_EN
    , .cts_n(cts[0])
`endif
  );

  buffered_uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(D1), .FIFO_DEPTH(DEP1),
                           .PARITY(PAR1), .STOP_BITS(SB1)) dut_b (
    .clk(clk), .rst(rst), .data(d1), .data_valid(dv[1]), .data_ready(rdy[1]),
    .full(ful[1]), .empty(emp[1]), .level(lvl1), .overflow(ovf[1]), .busy(bsy[1]),
    .uart_tx(tx[1])
`ifdef BUF_UART_TX_CTS_EN
    , .cts_n(cts[1])
`endif
  );

  buffered_uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(D2), .FIFO_DEPTH(DEP2),
                           .PARITY(PAR2), .STOP_BITS(SB2)) dut_c (
    .clk(clk), .rst(rst), .data(d2), .data_valid(dv[2]), .data_ready(rdy[2]),
    .full(ful[2]), .empty(emp[2]), .level(lvl2), .overflow(ovf[2]), .busy(bsy[2]),
    .uart_tx(tx[2])
`ifdef BUF_UART_TX_CTS_EN
    , .cts_n(cts[2])
`endif
  );

  function automatic int db(int k);
    case (k) 0: return D0; 1: return D1; default: return D2; endcase
  endfunction
  function automatic int dep(int k);
    case (k) 0: return DEP0; 1: return DEP1; default: return DEP2; endcase
  endfunction
  function automatic int par(int k);
    case (k) 0: return PAR0; 1: return PAR1; default: return PAR2; endcase
  endfunction
  function automatic int sb(int k);
    case (k) 0: return SB0; 1: return SB1; default: return SB2; endcase
  endfunction
  function automatic int flen(int k);
    return (1 + db(k) + ((par(k) != 0) ? 1 : 0) + sb(k)) * C;
  endfunction
  function automatic logic [8:0] wdata(int k);
    case (k) 0: return {1'b0, d0}; 1: return {1'b0, d1}; default: return {2'b00, d2}; endcase
  endfunction
  function automatic logic [8:0] lvl_of(int k);
    case (k) 0: return {4'h0, lvl0}; 1: return {6'h00, lvl1}; default: return {4'h0, lvl2}; endcase
  endfunction
  function automatic bit cts_ok(int k);
`ifdef BUF_UART_TX_CTS_EN
    return !cts[k];
`else
    return (k >= 0);
`endif
  endfunction

  // Expected line level for bit slot j of a frame carrying word w.
  function automatic logic exp_bit(int k, logic [8:0] w, int j);
    logic [8:0] m;
    m = w & ((9'd1 << db(k)) - 9'd1);
    if (j == 0) return 1'b0;
    if (j <= db(k)) return m[j-1];
    if (par(k) != 0 && j == db(k) + 1) return (par(k) == 2) ? ^m : ~^m;
    return 1'b1;
  endfunction

  task automatic chk(string tag, int k, logic [8:0] obs, logic [8:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s[%0d] cycle %0d: observed %0h expected %0h", tag, k, cyc, obs, exp);
    end
  endtask

  // Frame-level model: a new frame may start once the previous one has used its full length.
  task automatic model_edge();
    bit idle, full_pre, go;
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        mq[k].delete();
        act[k]  = 1'b0;
        movf[k] = 1'b0;
      end else begin
        idle     = !act[k] || (cyc - fs[k] >= flen(k));
        full_pre = (mq[k].size() >= dep(k));
        go       = idle && (mq[k].size() > 0) && cts_ok(k);
        if (go) begin
          fd[k]  = mq[k].pop_front();
          fs[k]  = cyc;
          act[k] = 1'b1;
        end else if (idle) begin
          act[k] = 1'b0;
        end
        if (dv[k]) begin
          if (full_pre) movf[k] = 1'b1;
          else mq[k].push_back(wdata(k));
        end
      end
    end
    cyc++;
  endtask

  task automatic check_all();
    logic etx, ebusy;
    int   sz;
    for (int k = 0; k < NI; k++) begin
      if (act[k]) begin
        etx   = exp_bit(k, fd[k], (cyc - 1 - fs[k]) / C);
        ebusy = 1'b1;
      end else begin
        etx   = 1'b1;
        ebusy = 1'b0;
      end
      sz = mq[k].size();
      chk("uart_tx",    k, {8'h00, tx[k]},  {8'h00, etx});
      chk("busy",       k, {8'h00, bsy[k]}, {8'h00, ebusy});
      chk("level",      k, lvl_of(k),       9'(sz));
      chk("full",       k, {8'h00, ful[k]}, {8'h00, sz == dep(k)});
      chk("empty",      k, {8'h00, emp[k]}, {8'h00, sz == 0});
      chk("data_ready", k, {8'h00, rdy[k]}, {8'h00, sz != dep(k)});
      chk("overflow",   k, {8'h00, ovf[k]}, {8'h00, movf[k]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    for (int k = 0; k < NI; k++) dv[k] = 1'b0;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic put(int k, logic [8:0] v);
    dv[k] = 1'b1;
    case (k)
      0: d0 = v[7:0];
      1: d1 = v[7:0];
      default: d2 = v[6:0];
    endcase
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      dv[k] = 1'b0; act[k] = 1'b0; movf[k] = 1'b0; fs[k] = 0; fd[k] = 9'h000;
`ifdef BUF_UART_TX_CTS_EN
      cts[k] = 1'b0;
`endif
    end
    rst = 1'b1;
    run(2);
    rst = 1'b0;

    // 0xA5 even parity: start bit appears two edges after the write
    put(0, 9'h0A5);
    tick();
    chk("a5_level_after_write", 0, {4'h0, lvl0}, 9'd1);
    chk("a5_line_still_idle",   0, {8'h00, tx[0]}, 9'd1);
    tick();
    chk("a5_start_bit", 0, {8'h00, tx[0]}, 9'd0);
    chk("a5_popped",    0, {4'h0, lvl0}, 9'd0);
    run(50);

    // 0x07: even parity bit 1, odd parity bit 0; 0x7F on the 7N2 instance
    put(0, 9'h007); put(1, 9'h007); put(2, 9'h07F);
    tick();
    run(1 + 9 * C);
    chk("even_parity_07", 0, {8'h00, tx[0]}, 9'd1);
    chk("odd_parity_07",  1, {8'h00, tx[1]}, 9'd0);
    chk("stop1_7n2",      2, {8'h00, tx[2]}, 9'd1);
    run(20);

    // back-to-back frames with no idle gap
    put(0, 9'h011); tick();
    put(0, 9'h022); tick();
    put(0, 9'h033); tick();
    chk("b2b_level", 0, {4'h0, lvl0}, 9'd2);
    run(3 * 11 * C + 10);

    // random traffic heavy enough to overflow, then drain
    for (int i = 0; i < 80; i++) begin
      for (int k = 0; k < NI; k++) begin
        if ($urandom_range(0, 99) < 60) put(k, 9'($urandom_range(0, 511)));
      end
      tick();
    end
    run(900);

    // reset in the middle of DATA with entries queued
    for (int i = 0; i < 4; i++) begin
      put(0, 9'($urandom_range(0, 255)));
      tick();
    end
    run(6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_line_high", 0, {8'h00, tx[0]},  9'd1);
    chk("rst_level",     0, {4'h0, lvl0},    9'd0);
    chk("rst_empty",     0, {8'h00, emp[0]}, 9'd1);
    chk("rst_busy",      0, {8'h00, bsy[0]}, 9'd0);
    run(60);

`ifdef BUF_UART_TX_CTS_EN
    // hold off the serializer, overfill the FIFO, then release
    cts[0] = 1'b1;
    for (int i = 0; i < 17; i++) begin
      put(0, 9'($urandom_range(0, 255)));
      tick();
      if (i == 15) begin
        chk("cts_full",  0, {8'h00, ful[0]}, 9'd1);
        chk("cts_level", 0, {4'h0, lvl0},    9'd16);
      end
    end
    chk("cts_overflow", 0, {8'h00, ovf[0]}, 9'd1);
    run(5);
    cts[0] = 1'b0;
    run(16 * 11 * C + 10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
